// File: rtl/conv_index_ctrl_if.sv
// conv_index_ctrl_if: request, x-index feedback and memory/accumulator control bundle for conv_index_ctrl
interface conv_index_ctrl_if;
  logic       start;
  logic [5:0] size_x;
  logic [5:0] size_y;
  logic [5:0] x_ind_q;
  logic [5:0] x_ind_next;
  logic       x_ind_en;
  logic       x_ind_clr;
  logic [4:0] x_addr;
  logic [4:0] y_addr;
  logic [5:0] z_addr;
  logic       acc_clr;
  logic       acc_en;
  logic       z_we;
  logic       busy;
  logic       done;
  modport master (
    output start, size_x, size_y, x_ind_q,
    input  x_ind_next, x_ind_en, x_ind_clr, x_addr, y_addr, z_addr,
           acc_clr, acc_en, z_we, busy, done
  );
  modport slave (
    input  start, size_x, size_y, x_ind_q,
    output x_ind_next, x_ind_en, x_ind_clr, x_addr, y_addr, z_addr,
           acc_clr, acc_en, z_we, busy, done
  );
endinterface

// File: rtl/conv_index_ctrl.sv
// conv_index_ctrl: sequences x index, addresses and accumulator control for direct-form convolution
module conv_index_ctrl (
  input  logic              clk,
  input  logic              rstn,
  conv_index_ctrl_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, INIT, CALC, DRAIN, WRITE, DONE} state_t;
  state_t     state;
  logic [5:0] sx, sy, i;
  logic       acc_en_q;
  logic [5:0] cx, cy, diff;
  logic [6:0] l_idx;
  logic       last, term_valid;
  always_comb begin
    cx         = bus.size_x > 6'd32 ? 6'd32 : bus.size_x;
    cy         = bus.size_y > 6'd32 ? 6'd32 : bus.size_y;
    diff       = i - bus.x_ind_q;
    last       = bus.x_ind_q == sx - 6'd1;
    term_valid = (i >= bus.x_ind_q) && (diff < sy);
    l_idx      = {1'b0, sx} + {1'b0, sy} - 7'd2;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      sx       <= '0;
      sy       <= '0;
      i        <= '0;
      acc_en_q <= 1'b0;
    end else begin
      // accumulate one cycle after the term is issued, matching memory read latency
      acc_en_q <= (state == CALC) && term_valid;
      case (state)
        IDLE: if (bus.start) begin
          sx    <= cx;
          sy    <= cy;
          state <= (cx == 6'd0 || cy == 6'd0) ? DONE : INIT;
        end
        INIT: begin
          i     <= '0;
          state <= CALC;
        end
        CALC: if (last) state <= DRAIN;
        DRAIN: state <= WRITE;
        WRITE: if ({1'b0, i} == l_idx) state <= DONE;
        else begin
          i     <= i + 6'd1;
          state <= CALC;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  always_comb begin
    bus.x_ind_next = bus.x_ind_q + 6'd1;
    bus.x_ind_en   = (state == CALC) && !last;
    bus.x_ind_clr  = (state == INIT) || ((state == CALC) && last);
    bus.x_addr     = bus.x_ind_q[4:0];
    bus.y_addr     = diff[4:0];
    bus.z_addr     = i;
    bus.acc_clr    = (state == INIT) || (state == WRITE);
    bus.acc_en     = acc_en_q;
    bus.z_we       = state == WRITE;
    bus.busy       = state != IDLE;
    bus.done       = state == DONE;
  end
endmodule

// File: tb/tb_conv_index_ctrl.sv
// tb_conv_index_ctrl: directed checks of conv_index_ctrl with a behavioural x index register
module tb_conv_index_ctrl;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  conv_index_ctrl_if bus ();
  conv_index_ctrl dut (.clk(clk), .rstn(rstn), .bus(bus));
  always #5 clk = ~clk;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) bus.x_ind_q <= '0;
    else if (bus.x_ind_clr) bus.x_ind_q <= '0;
    else if (bus.x_ind_en) bus.x_ind_q <= bus.x_ind_next;
  end
  int n_checks = 0, n_fail = 0;
  int cyc, done_cyc, writes, acc_tot, last_addr, en_cnt, max_x, conflicts;
  int addr_err, align_err, busy_cyc, min_per, max_per, run_acc;
  int per_out[64];
  logic prev_valid;
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic run_job(input int sx_in, input int sy_in, input int glitch_at);
    int sy_eff, xq, z, calc;
    sy_eff = sy_in > 32 ? 32 : sy_in;
    {writes, acc_tot, en_cnt, max_x, conflicts, addr_err, align_err, busy_cyc, run_acc} = '0;
    min_per = 999; max_per = -1; last_addr = -1; done_cyc = -1; prev_valid = 1'b0;
    @(negedge clk);
    bus.size_x = 6'(sx_in); bus.size_y = 6'(sy_in); bus.start = 1'b1; cyc = 0;
    while (done_cyc < 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      bus.start = (cyc == glitch_at);
      xq = int'(bus.x_ind_q); z = int'(bus.z_addr);
      calc = int'(bus.x_ind_en | (bus.x_ind_clr & !bus.acc_clr));
      if (bus.acc_en !== prev_valid) align_err++;
      prev_valid = (calc != 0) && (z >= xq) && (((z - xq) & 63) < sy_eff);
      if (bus.x_addr != 5'(xq) || bus.x_ind_next != 6'(xq + 1) || bus.y_addr != 5'((z - xq) & 31)) addr_err++;
      if (bus.busy) busy_cyc++;
      if (bus.acc_en) begin acc_tot++; run_acc++; end
      if (bus.z_we) begin
        per_out[writes] = run_acc;
        if (run_acc < min_per) min_per = run_acc;
        if (run_acc > max_per) max_per = run_acc;
        writes++; last_addr = z; run_acc = 0;
      end
      if (bus.x_ind_en) en_cnt++;
      if (bus.x_ind_en && bus.x_ind_clr) conflicts++;
      if (xq > max_x) max_x = xq;
      if (bus.done) done_cyc = cyc;
    end
    bus.start = 1'b0;
  endtask
  task automatic check_idle_outputs(input string tag);
    check({tag, "_ctl"}, int'({bus.busy, bus.done, bus.z_we, bus.acc_en, bus.acc_clr, bus.x_ind_en, bus.x_ind_clr}), 0);
    check({tag, "_zaddr"}, int'(bus.z_addr), 0);
  endtask
  initial begin
    bus.start = 1'b0; bus.size_x = '0; bus.size_y = '0;
    #1;
    check_idle_outputs("reset");
    check("reset_xnext", int'(bus.x_ind_next), 1);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    run_job(2, 2, -1);
    check("j22_done", done_cyc, 14);
    check("j22_busy", busy_cyc, 14);
    check("j22_writes", writes, 3);
    check("j22_acc", acc_tot, 4);
    run_job(3, 2, -1);
    check("j32_done", done_cyc, 22);
    check("j32_writes", writes, 4);
    check("j32_last", last_addr, 3);
    check("j32_acc", acc_tot, 6);
    check("j32_p0", per_out[0], 1);
    check("j32_p1", per_out[1], 2);
    check("j32_p2", per_out[2], 2);
    check("j32_p3", per_out[3], 1);
    check("j32_align", align_err, 0);
    check("j32_addr", addr_err, 0);
    run_job(1, 1, -1);
    check("j11_done", done_cyc, 5);
    check("j11_en", en_cnt, 0);
    check("j11_acc", acc_tot, 1);
    check("j11_writes", writes, 1);
    check("j11_last", last_addr, 0);
    run_job(32, 32, -1);
    check("j3232_done", done_cyc, 2144);
    check("j3232_writes", writes, 63);
    check("j3232_last", last_addr, 62);
    check("j3232_acc", acc_tot, 1024);
    check("j3232_maxx", max_x, 31);
    check("j3232_conflict", conflicts, 0);
    check("j3232_align", align_err, 0);
    check("j3232_addr", addr_err, 0);
    run_job(0, 5, -1);
    check("j05_done", done_cyc, 1);
    check("j05_busy", busy_cyc, 1);
    check("j05_writes", writes, 0);
    run_job(4, 4, 10);
    check("j44_done", done_cyc, 44);
    check("j44_writes", writes, 7);
    check("j44_acc", acc_tot, 16);
    run_job(40, 1, -1);
    check("j401_done", done_cyc, 1090);
    check("j401_writes", writes, 32);
    check("j401_minper", min_per, 1);
    check("j401_maxper", max_per, 1);
    // abort a running job with an asynchronous reset mid-CALC
    @(negedge clk);
    bus.size_x = 6'd4; bus.size_y = 6'd4; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_busy", int'(bus.busy), 1);
    #2 rstn = 1'b0;
    #1;
    check_idle_outputs("midreset");
    @(negedge clk);
    rstn = 1'b1;
    run_job(2, 2, -1);
    check("post_done", done_cyc, 14);
    check("post_writes", writes, 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
